memp_sweep_controller: RTL and testbench
========================================

Name: memp_sweep_controller

Overview:
- Sequences one full sweep over the P-vector memory: streams clusters 0..number_of_clusters-1 to a downstream consumer over valid/ready.
- Optionally accepts updated clusters back from the update unit and writes them in order.
- Signals completion to the top-level solver FSM.
- Sits between the P memory (combinational read, synchronous write) and the matrix-vector / update datapath.

Parameters:
- number_of_clusters, 1, memory depth in words; a sweep covers indices 0..number_of_clusters-1.
- number_of_equations_per_cluster, 9, elements per memory word.
- element_width, 64, bits per element.
- address_width, 20, width of the memory addresses and the internal counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle sweep request; honoured only in IDLE.
- wb_mode  input  1  sampled with start; 1 = read then write back every cluster, 0 = read only.
- busy  output  1  high in STREAM and DRAIN.
- finish  output  1  one-cycle pulse when the sweep completes.
- mem_read_address  output  address_width  read index to the memory.
- mem_data  input  number_of_equations_per_cluster*element_width  memory read data (combinational from mem_read_address).
- mem_write_address  output  address_width  write index to the memory.
- mem_write_data  output  number_of_equations_per_cluster*element_width  write data to the memory.
- mem_write_enable  output  1  write strobe to the memory.
- rd_data  output  number_of_equations_per_cluster*element_width  cluster streamed to the consumer.
- rd_index  output  address_width  index of rd_data.
- rd_valid  output  1  rd_data is valid.
- rd_ready  input  1  consumer accepts.
- wb_data  input  number_of_equations_per_cluster*element_width  updated cluster from the update unit.
- wb_valid  input  1  wb_data is valid.
- wb_ready  output  1  controller accepts wb_data.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; rd_cnt=0, wr_cnt=0, mode register=0.
  - busy=0, finish=0, rd_valid=0, wb_ready=0, mem_write_enable=0.
  - mem_read_address=0, mem_write_address=0, rd_index=0.
- States:
  - IDLE: start=1 → STREAM; latch wb_mode; clear rd_cnt and wr_cnt. Otherwise stay.
  - STREAM:
    - rd_valid=1, mem_read_address=rd_index=rd_cnt, rd_data=mem_data.
    - rd_valid & rd_ready → rd_cnt+1.
    - When the last read (rd_cnt=number_of_clusters-1) is accepted: → DRAIN if mode=1, else → DONE.
  - DRAIN: rd_valid=0; write-back continues until wr_cnt=number_of_clusters, then → DONE.
  - DONE: finish=1 for exactly this cycle, then → IDLE.
- Read stream:
  - rd_data, rd_index and rd_valid hold stable while rd_valid & !rd_ready.
  - Throughput is one cluster per cycle when rd_ready is held high.
  - A sweep of N clusters with wb_mode=0 and rd_ready=1 gives start at cycle 0, reads in cycles 1..N, finish at cycle N+1.
- Write-back (mode=1, in STREAM or DRAIN):
  - wb_ready=1 iff wr_cnt < rd_cnt and wr_cnt < number_of_clusters. A cluster is never written before it has been read (no RAW hazard on the read port).
  - mem_write_enable = wb_valid & wb_ready (combinational); mem_write_address=wr_cnt; mem_write_data=wb_data.
  - Each handshake increments wr_cnt.
  - A read of index k and a write of index j<k in the same cycle are legal.
  - In mode=0, wb_ready=0 and mem_write_enable=0 always.
- Completion condition: mode=0 → all reads accepted; mode=1 → all reads accepted and wr_cnt=number_of_clusters.
- Boundaries:
  - start outside IDLE (including the DONE cycle) is ignored.
  - wb_valid in IDLE is ignored (wb_ready=0).
  - number_of_clusters=1: one read and at most one write, then finish.
  - Counters never wrap: rd_cnt saturates at number_of_clusters and stops incrementing.
  - rst_n asserted mid-sweep aborts immediately to the reset state with no finish pulse. Memory contents already written stay written.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, STREAM, DRAIN, DONE);
  - cluster word width = number_of_equations_per_cluster*element_width;
  - default address_width.
- No sub-module: one FSM plus two counters and the combinational handshake logic, in a single module.

Test Plan:
- N=4, wb_mode=0, rd_ready=1, start pulse → rd_index 0,1,2,3 on consecutive cycles; rd_data equals the preloaded words; finish the cycle after index 3 is accepted; no mem_write_enable.
- N=4, wb_mode=0, rd_ready toggling 1,0,0,1,… → rd_data and rd_index hold through stalls; each index delivered exactly once; finish once.
- N=4, wb_mode=1, wb_valid=1 from cycle 0 with wb_data=index+0x100 → wb_ready low until index 0 has been read; writes to addresses 0..3 in order; memory holds the new values; finish after the 4th write.
- N=4, wb_mode=1, all reads done, writes delayed 5 cycles → controller sits in DRAIN with busy=1 and rd_valid=0; finish only after the last write.
- start pulsed during STREAM and in the DONE cycle → ignored; counters unaffected; exactly one finish.
- rst_n low for one cycle after the 2nd read → all outputs return to reset values; no finish; a new start runs a clean full sweep from index 0.

Source files
------------

// File: rtl/memp_sweep_controller_pkg.sv
// Shared types and defaults for the P-vector memory sweep controller.
// Holds the FSM state encoding and the default cluster word geometry.
package memp_sweep_controller_pkg;

   typedef enum logic [1:0] {
      st_idle   = 2'd0,
      st_stream = 2'd1,
      st_drain  = 2'd2,
      st_done   = 2'd3
   } sweep_state_t;

   function automatic int unsigned cluster_width(input int unsigned equations,
                                                 input int unsigned elem_width);
      return equations * elem_width;
   endfunction

   localparam int unsigned default_address_width         = 20;
   localparam int unsigned default_equations_per_cluster = 9;
   localparam int unsigned default_element_width         = 64;
   localparam int unsigned default_cluster_width         =
      cluster_width(default_equations_per_cluster, default_element_width);

endpackage

// File: rtl/memp_sweep_controller.sv
// Streams every cluster of the P memory to the consumer once per sweep and,
// in write-back mode, writes the updated clusters back in the same order.
module memp_sweep_controller
   import memp_sweep_controller_pkg::*;
#(
   parameter int unsigned number_of_clusters              = 1,
   parameter int unsigned number_of_equations_per_cluster = default_equations_per_cluster,
   parameter int unsigned element_width                   = default_element_width,
   parameter int unsigned address_width                   = default_address_width,
   localparam int unsigned word_width =
      cluster_width(number_of_equations_per_cluster, element_width)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     wb_mode,
   output logic                     busy,
   output logic                     finish,
   output logic [address_width-1:0] mem_read_address,
   input  logic [word_width-1:0]    mem_data,
   output logic [address_width-1:0] mem_write_address,
   output logic [word_width-1:0]    mem_write_data,
   output logic                     mem_write_enable,
   output logic [word_width-1:0]    rd_data,
   output logic [address_width-1:0] rd_index,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   input  logic [word_width-1:0]    wb_data,
   input  logic                     wb_valid,
   output logic                     wb_ready
);

   localparam logic [address_width-1:0] cnt_max  = address_width'(number_of_clusters);
   localparam logic [address_width-1:0] last_idx = address_width'(number_of_clusters - 1);
   localparam logic [address_width-1:0] cnt_one  = address_width'(1);
   localparam logic [address_width-1:0] cnt_zero = address_width'(0);

   sweep_state_t             state_r;
   sweep_state_t             state_s;
   logic [address_width-1:0] rd_cnt_r;
   logic [address_width-1:0] wr_cnt_r;
   logic                     mode_r;
   logic                     rd_fire_s;
   logic                     wb_fire_s;

   assign rd_fire_s         = rd_valid & rd_ready;
   assign wb_fire_s         = mem_write_enable;
   assign mem_write_address = wr_cnt_r;
   assign mem_write_data    = wb_data;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= st_idle;
      end else begin
         state_r <= state_s;
      end
   end

   // Read/write counters and the write-back mode latched with start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt_r <= cnt_zero;
         wr_cnt_r <= cnt_zero;
         mode_r   <= 1'b0;
      end else if ((state_r == st_idle) && start) begin
         rd_cnt_r <= cnt_zero;
         wr_cnt_r <= cnt_zero;
         mode_r   <= wb_mode;
      end else begin
         // Both counters saturate at the cluster count and never wrap.
         if (rd_fire_s && (rd_cnt_r < cnt_max)) begin
            rd_cnt_r <= rd_cnt_r + cnt_one;
         end
         if (wb_fire_s && (wr_cnt_r < cnt_max)) begin
            wr_cnt_r <= wr_cnt_r + cnt_one;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         st_idle: begin
            if (start) begin
               state_s = st_stream;
            end else begin
               state_s = st_idle;
            end
         end
         st_stream: begin
            if (rd_fire_s && (rd_cnt_r == last_idx)) begin
               state_s = mode_r ? st_drain : st_done;
            end else begin
               state_s = st_stream;
            end
         end
         st_drain: begin
            // Leave as soon as the final write handshakes, not a cycle later.
            if ((wr_cnt_r == cnt_max) || (wb_fire_s && (wr_cnt_r == last_idx))) begin
               state_s = st_done;
            end else begin
               state_s = st_drain;
            end
         end
         st_done: begin
            state_s = st_idle;
         end
         default: begin
            state_s = st_idle;
         end
      endcase
   end

   // Output decode and handshake logic.
   always_comb begin
      busy             = 1'b0;
      finish           = 1'b0;
      rd_valid         = 1'b0;
      rd_index         = cnt_zero;
      mem_read_address = cnt_zero;
      rd_data          = {word_width{1'b0}};
      case (state_r)
         st_idle: begin
            busy = 1'b0;
         end
         st_stream: begin
            busy             = 1'b1;
            rd_valid         = 1'b1;
            rd_index         = rd_cnt_r;
            mem_read_address = rd_cnt_r;
            rd_data          = mem_data;
         end
         st_drain: begin
            busy = 1'b1;
         end
         st_done: begin
            finish = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
      // A cluster is only accepted back once it has already been read out.
      wb_ready         = mode_r & busy & (wr_cnt_r < rd_cnt_r) & (wr_cnt_r < cnt_max);
      mem_write_enable = wb_valid & wb_ready;
   end

endmodule

// File: tb/tb_memp_sweep_controller.sv
// Directed bench for memp_sweep_controller with a four-cluster behavioural
// memory (combinational read, synchronous write).
module tb_memp_sweep_controller;

   localparam int unsigned n_cl = 4;
   localparam int unsigned aw   = 8;
   localparam int unsigned ww   = 32;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          wb_mode;
   logic          busy;
   logic          finish;
   logic [aw-1:0] mem_read_address;
   logic [ww-1:0] mem_data;
   logic [aw-1:0] mem_write_address;
   logic [ww-1:0] mem_write_data;
   logic          mem_write_enable;
   logic [ww-1:0] rd_data;
   logic [aw-1:0] rd_index;
   logic          rd_valid;
   logic          rd_ready;
   logic [ww-1:0] wb_data;
   logic          wb_valid;
   logic          wb_ready;

   logic          preload;
   logic [ww-1:0] mem [0:3];
   int            total;
   int            bad;
   int            fin_cnt;
   int            wr_seen;

   memp_sweep_controller #(
      .number_of_clusters              (n_cl),
      .number_of_equations_per_cluster (2),
      .element_width                   (16),
      .address_width                   (aw)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start             (start),
      .wb_mode           (wb_mode),
      .busy              (busy),
      .finish            (finish),
      .mem_read_address  (mem_read_address),
      .mem_data          (mem_data),
      .mem_write_address (mem_write_address),
      .mem_write_data    (mem_write_data),
      .mem_write_enable  (mem_write_enable),
      .rd_data           (rd_data),
      .rd_index          (rd_index),
      .rd_valid          (rd_valid),
      .rd_ready          (rd_ready),
      .wb_data           (wb_data),
      .wb_valid          (wb_valid),
      .wb_ready          (wb_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_data = (mem_read_address < 8'd4) ? mem[mem_read_address[1:0]] : 32'd0;

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 4; i++) mem[i] <= 32'hA000_0000 + 32'(i);
      end else if (mem_write_enable && (mem_write_address < 8'd4)) begin
         mem[mem_write_address[1:0]] <= mem_write_data;
      end
   end

   always @(posedge clk) begin
      if (finish) fin_cnt++;
      if (mem_write_enable) wr_seen++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int idx;
      int c;
      int widx;
      total = 0; bad = 0; fin_cnt = 0; wr_seen = 0;
      rst_n = 1'b0; start = 1'b0; wb_mode = 1'b0; rd_ready = 1'b0;
      wb_valid = 1'b0; wb_data = 32'd0; preload = 1'b1;
      tick(); tick();
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_finish", finish, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_wb_ready", wb_ready, 0);
      chk("rst_we", mem_write_enable, 0);
      chk("rst_raddr", mem_read_address, 0);
      chk("rst_waddr", mem_write_address, 0);
      chk("rst_rd_index", rd_index, 0);
      preload = 1'b0; rst_n = 1'b1;
      tick();

      // Read-only sweep with the consumer always ready; wb_valid must be ignored.
      start = 1'b1; wb_mode = 1'b0; rd_ready = 1'b1; wb_valid = 1'b1; wb_data = 32'h55;
      #1;
      chk("t1_idle_busy", busy, 0);
      chk("t1_idle_wb_ready", wb_ready, 0);
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t1_rd_valid", rd_valid, 1);
         chk("t1_rd_index", rd_index, i);
         chk("t1_rd_data", rd_data, 32'hA000_0000 + 32'(i));
         chk("t1_wb_ready", wb_ready, 0);
         chk("t1_we", mem_write_enable, 0);
         tick();
      end
      #1;
      chk("t1_finish", finish, 1);
      chk("t1_done_busy", busy, 0);
      tick();
      #1;
      chk("t1_finish_clear", finish, 0);
      chk("t1_no_writes", wr_seen, 0);
      wb_valid = 1'b0;

      // Read-only sweep with consumer stalls: ready pattern 1,0,0 repeating.
      start = 1'b1;
      tick();
      start = 1'b0; idx = 0; c = 0;
      while ((idx < 4) && (c < 40)) begin
         rd_ready = ((c % 3) == 0);
         #1;
         chk("t2_rd_valid", rd_valid, 1);
         chk("t2_rd_index", rd_index, idx);
         chk("t2_rd_data", rd_data, 32'hA000_0000 + 32'(idx));
         if (rd_ready) idx++;
         c++;
         tick();
      end
      chk("t2_all_read", idx, 4);
      chk("t2_cycles", c, 10);
      #1;
      chk("t2_finish", finish, 1);
      rd_ready = 1'b1;
      tick();

      // Write-back sweep with wb_valid held high from the start cycle.
      start = 1'b1; wb_mode = 1'b1; wb_valid = 1'b1; wb_data = 32'h100;
      #1;
      chk("t3_idle_wb_ready", wb_ready, 0);
      tick();
      start = 1'b0; widx = 0;
      for (int cy = 1; cy <= 4; cy++) begin
         wb_data = 32'h100 + 32'(widx);
         #1;
         chk("t3_rd_index", rd_index, cy - 1);
         chk("t3_wb_ready", wb_ready, (cy >= 2) ? 1 : 0);
         chk("t3_we", mem_write_enable, (cy >= 2) ? 1 : 0);
         if (cy >= 2) begin
            chk("t3_waddr", mem_write_address, widx);
            widx++;
         end
         tick();
      end
      wb_data = 32'h103;
      #1;
      chk("t3_drain_busy", busy, 1);
      chk("t3_drain_rd_valid", rd_valid, 0);
      chk("t3_drain_waddr", mem_write_address, 3);
      chk("t3_drain_we", mem_write_enable, 1);
      tick();
      #1;
      chk("t3_finish", finish, 1);
      chk("t3_done_wb_ready", wb_ready, 0);
      wb_valid = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) chk("t3_mem", mem[i], 32'h100 + 32'(i));
      preload = 1'b1;
      tick();
      preload = 1'b0;

      // Write-back sweep whose writes arrive only after a 5-cycle drain wait.
      start = 1'b1; wb_mode = 1'b1; wb_valid = 1'b0;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t4_rd_index", rd_index, i);
         tick();
      end
      for (int d = 0; d < 5; d++) begin
         #1;
         chk("t4_drain_busy", busy, 1);
         chk("t4_drain_rd_valid", rd_valid, 0);
         chk("t4_drain_finish", finish, 0);
         tick();
      end
      wb_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wb_data = 32'h200 + 32'(k);
         #1;
         chk("t4_waddr", mem_write_address, k);
         chk("t4_we", mem_write_enable, 1);
         chk("t4_no_early_finish", finish, 0);
         tick();
      end
      wb_valid = 1'b0;
      #1;
      chk("t4_finish", finish, 1);
      tick();
      chk("t4_mem3", mem[3], 32'h203);
      chk("t4_mem0", mem[0], 32'h200);
      preload = 1'b1;
      tick();
      preload = 1'b0;

      // start pulses during STREAM and in the DONE cycle must be ignored.
      start = 1'b1; wb_mode = 1'b0; rd_ready = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         start = (i == 1);
         #1;
         chk("t5_rd_index", rd_index, i);
         chk("t5_busy", busy, 1);
         tick();
      end
      start = 1'b1;
      #1;
      chk("t5_finish", finish, 1);
      tick();
      start = 1'b0;
      #1;
      chk("t5_idle_busy", busy, 0);
      chk("t5_idle_rd_valid", rd_valid, 0);
      tick();
      #1;
      chk("t5_still_idle", busy, 0);
      chk("t5_finish_count", fin_cnt, 5);

      // Asynchronous reset after the second read aborts without a finish.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("t6_rd_index", rd_index, i);
         tick();
      end
      rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_rd_valid", rd_valid, 0);
      chk("t6_rst_rd_index", rd_index, 0);
      chk("t6_rst_raddr", mem_read_address, 0);
      chk("t6_rst_finish", finish, 0);
      tick();
      rst_n = 1'b1;
      tick(); tick();
      chk("t6_no_finish", fin_cnt, 5);
      chk("t6_idle_busy", busy, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t6_re_rd_index", rd_index, i);
         chk("t6_re_rd_data", rd_data, 32'hA000_0000 + 32'(i));
         tick();
      end
      #1;
      chk("t6_finish", finish, 1);
      tick();
      chk("t6_finish_count", fin_cnt, 6);
      chk("total_writes", wr_seen, 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
